// File: rtl/bus_pkg.sv
// Shared types and defaults for the serial bus arbiter fabric.
// Pure declarations: no logic, no latency, no flow control.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ID      = 2'd1,
    CONNECT = 2'd2
  } arb_state_t;

  localparam int DEF_NO_MASTERS = 2;
  localparam int DEF_NO_SLAVES  = 3;
  localparam int SLAVE_NONE     = 0;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first requester scanning last+1, last+2, ... modulo NO_MASTERS.
// Purely combinational, zero latency; no backpressure, any=0 when nobody requests.
module rr_priority_pick #(
  parameter int NO_MASTERS = 2,
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
  input  logic [NO_MASTERS-1:0] req,
  input  logic [M_ID_WIDTH-1:0] last,
  output logic [M_ID_WIDTH-1:0] pick,
  output logic                  any
);

  logic [M_ID_WIDTH-1:0] w_idx;

  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= NO_MASTERS; i++) begin
      w_idx = M_ID_WIDTH'((int'(last) + i) % NO_MASTERS);
      if (!any && req[w_idx]) begin
        pick = w_idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: grants one master, shifts in its serial slave ID, drives mux selects.
// All outputs registered; grant one cycle after req; masters hold req level, no queueing.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NO_MASTERS = DEF_NO_MASTERS,
  parameter int NO_SLAVES  = DEF_NO_SLAVES,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS),
  parameter int MAX_HOLD   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NO_MASTERS-1:0] req,
  input  logic [NO_MASTERS-1:0] id_in,
  output logic [NO_MASTERS-1:0] grant,
  output logic [M_ID_WIDTH-1:0] master_sel,
  output logic [S_ID_WIDTH-1:0] slave_sel,
  output logic                  bus_valid,
  output logic                  id_err,
  output logic                  timeout
);

  localparam int BC_W = (S_ID_WIDTH > 1) ? $clog2(S_ID_WIDTH) : 1;
  localparam int H_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [BC_W-1:0]       BIT_LAST = BC_W'(S_ID_WIDTH - 1);
  localparam logic [S_ID_WIDTH-1:0] SLV_MAX  = S_ID_WIDTH'(NO_SLAVES);
  localparam logic [S_ID_WIDTH-1:0] SLV_NONE = S_ID_WIDTH'(SLAVE_NONE);
  // With no hold limit the counter just saturates at all-ones and is never compared.
  localparam logic [H_W-1:0] HOLD_LIM = (MAX_HOLD != 0) ? H_W'(MAX_HOLD - 1) : {H_W{1'b1}};

  arb_state_t              r_state;
  logic [M_ID_WIDTH-1:0]   r_last;
  logic [NO_MASTERS-1:0]   r_grant;
  logic [M_ID_WIDTH-1:0]   r_master_sel;
  logic [S_ID_WIDTH-1:0]   r_slave_sel;
  logic                    r_bus_valid;
  logic                    r_id_err;
  logic                    r_timeout;
  logic [S_ID_WIDTH-1:0]   r_id_sr;
  logic [BC_W-1:0]         r_bit_cnt;
  logic [H_W-1:0]          r_hold_cnt;

  logic [M_ID_WIDTH-1:0]   w_pick;
  logic                    w_any;
  logic                    w_req_m;
  logic                    w_others;
  logic                    w_id_valid;
  logic [S_ID_WIDTH-1:0]   w_id_next;

  rr_priority_pick #(
    .NO_MASTERS (NO_MASTERS),
    .M_ID_WIDTH (M_ID_WIDTH)
  ) u_pick (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );

  assign w_req_m    = req[r_master_sel];
  assign w_others   = |(req & ~r_grant);
  assign w_id_next  = S_ID_WIDTH'({r_id_sr, id_in[r_master_sel]});
  assign w_id_valid = (w_id_next != SLV_NONE) && (w_id_next <= SLV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= M_ID_WIDTH'(NO_MASTERS - 1);
      r_grant      <= '0;
      r_master_sel <= '0;
      r_slave_sel  <= SLV_NONE;
      r_bus_valid  <= 1'b0;
      r_id_err     <= 1'b0;
      r_timeout    <= 1'b0;
      r_id_sr      <= '0;
      r_bit_cnt    <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_id_err  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= ID;
            r_grant      <= {{(NO_MASTERS-1){1'b0}}, 1'b1} << w_pick;
            r_master_sel <= w_pick;
            r_bit_cnt    <= '0;
            r_id_sr      <= '0;
          end
        end
        ID: begin
          if (!w_req_m) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= r_master_sel;
          end else begin
            r_id_sr   <= w_id_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              if (w_id_valid) begin
                r_state     <= CONNECT;
                r_slave_sel <= w_id_next;
                r_bus_valid <= 1'b1;
                r_hold_cnt  <= '0;
              end else begin
                r_state  <= IDLE;
                r_grant  <= '0;
                r_last   <= r_master_sel;
                r_id_err <= 1'b1;
              end
            end
          end
        end
        CONNECT: begin
          // A voluntary release takes precedence, so timeout only flags a forced one.
          if (!w_req_m || (MAX_HOLD != 0 && r_hold_cnt == HOLD_LIM && w_others)) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_bus_valid <= 1'b0;
            r_slave_sel <= SLV_NONE;
            r_last      <= r_master_sel;
            r_timeout   <= w_req_m;
          end else if (r_hold_cnt != HOLD_LIM) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign master_sel = r_master_sel;
  assign slave_sel  = r_slave_sel;
  assign bus_valid  = r_bus_valid;
  assign id_err     = r_id_err;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench: dut_a has MAX_HOLD=4, dut_b has no hold limit; both see the same inputs.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] id_in;

  logic [1:0] a_grant, b_grant;
  logic       a_msel, b_msel;
  logic [1:0] a_slave, b_slave;
  logic       a_valid, b_valid, a_err, b_err, a_tmo, b_tmo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NO_MASTERS(2), .NO_SLAVES(2), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .id_in(id_in),
    .grant(a_grant), .master_sel(a_msel), .slave_sel(a_slave),
    .bus_valid(a_valid), .id_err(a_err), .timeout(a_tmo)
  );

  bus_arbiter_rr #(.NO_MASTERS(2), .NO_SLAVES(2), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .id_in(id_in),
    .grant(b_grant), .master_sel(b_msel), .slave_sel(b_slave),
    .bus_valid(b_valid), .id_err(b_err), .timeout(b_tmo)
  );

  typedef struct {
    int         m;
    logic [1:0] id;
    logic [1:0] e_slave;
    logic       e_valid;
    logic       e_err;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string nm);
    chk({nm, ".grant"},   32'(a_grant), 32'd0);
    chk({nm, ".msel"},    32'(a_msel),  32'd0);
    chk({nm, ".slave"},   32'(a_slave), 32'd0);
    chk({nm, ".valid"},   32'(a_valid), 32'd0);
    chk({nm, ".id_err"},  32'(a_err),   32'd0);
    chk({nm, ".timeout"}, 32'(a_tmo),   32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    id_in = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int tcount;
    vt[0] = '{m: 0, id: 2'b01, e_slave: 2'd1, e_valid: 1'b1, e_err: 1'b0};
    vt[1] = '{m: 1, id: 2'b10, e_slave: 2'd2, e_valid: 1'b1, e_err: 1'b0};
    vt[2] = '{m: 1, id: 2'b00, e_slave: 2'd0, e_valid: 1'b0, e_err: 1'b1};
    vt[3] = '{m: 1, id: 2'b11, e_slave: 2'd0, e_valid: 1'b0, e_err: 1'b1};
    vt[4] = '{m: 0, id: 2'b10, e_slave: 2'd2, e_valid: 1'b1, e_err: 1'b0};
    vt[5] = '{m: 0, id: 2'b00, e_slave: 2'd0, e_valid: 1'b0, e_err: 1'b1};

    rst = 1'b1; req = 2'b00; id_in = 2'b00;
    tick(); tick();
    chk_idle_a("reset");
    rst = 1'b0;

    // Single-master transactions: grant, serial ID, connect or id_err, release.
    for (int i = 0; i < 6; i++) begin
      req = 2'(1 << vt[i].m);
      tick();
      chk($sformatf("v%0d.grant", i), 32'(a_grant), 32'(1 << vt[i].m));
      chk($sformatf("v%0d.msel", i),  32'(a_msel),  32'(vt[i].m));
      id_in = vt[i].id[1] ? 2'(1 << vt[i].m) : 2'b00;
      tick();
      id_in = vt[i].id[0] ? 2'(1 << vt[i].m) : 2'b00;
      tick();
      chk($sformatf("v%0d.slave", i),  32'(a_slave), 32'(vt[i].e_slave));
      chk($sformatf("v%0d.valid", i),  32'(a_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d.id_err", i), 32'(a_err),   32'(vt[i].e_err));
      chk($sformatf("v%0d.grant2", i), 32'(a_grant), vt[i].e_valid ? 32'(1 << vt[i].m) : 32'd0);
      chk($sformatf("v%0d.b_valid", i), 32'(b_valid), 32'(vt[i].e_valid));
      req = 2'b00;
      tick();
      chk($sformatf("v%0d.rel_grant", i), 32'(a_grant), 32'd0);
      chk($sformatf("v%0d.rel_valid", i), 32'(a_valid), 32'd0);
      chk($sformatf("v%0d.rel_slave", i), 32'(a_slave), 32'd0);
      chk($sformatf("v%0d.rel_err", i),   32'(a_err),   32'd0);
      chk($sformatf("v%0d.rel_msel", i),  32'(a_msel),  32'(vt[i].m));
      id_in = 2'b00;
      tick();
    end

    // Simultaneous requests after reset: round-robin hand-over both ways.
    do_reset();
    req = 2'b11;
    tick();
    chk("rr.first_grant", 32'(a_grant), 32'b01);
    id_in = 2'b00; tick();
    id_in = 2'b01; tick();
    chk("rr.m0_valid", 32'(a_valid), 32'd1);
    chk("rr.m0_slave", 32'(a_slave), 32'd1);
    req = 2'b10;
    tick();
    chk("rr.m0_rel", 32'(a_grant), 32'b00);
    tick();
    chk("rr.m1_grant", 32'(a_grant), 32'b10);
    chk("rr.m1_msel",  32'(a_msel),  32'd1);
    id_in = 2'b10; tick();
    id_in = 2'b00; tick();
    chk("rr.m1_slave", 32'(a_slave), 32'd2);
    req = 2'b01;
    tick();
    chk("rr.m1_rel", 32'(a_grant), 32'b00);
    tick();
    chk("rr.m0_regrant", 32'(a_grant), 32'b01);
    // Dropping req mid-ID aborts silently.
    req = 2'b00;
    tick();
    chk("abort.grant",  32'(a_grant), 32'b00);
    chk("abort.id_err", 32'(a_err),   32'd0);

    // Forced release on dut_a after 4 CONNECT cycles; dut_b never times out.
    req = 2'b01;
    tick();
    id_in = 2'b00; tick();
    id_in = 2'b01; tick();
    chk("hold.valid0", 32'(a_valid), 32'd1);
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold.valid%0d", i + 1), 32'(a_valid), 32'd1);
      chk($sformatf("hold.tmo%0d", i + 1),   32'(a_tmo),   32'd0);
    end
    tick();
    chk("hold.rel_grant", 32'(a_grant), 32'b00);
    chk("hold.rel_valid", 32'(a_valid), 32'd0);
    chk("hold.timeout",   32'(a_tmo),   32'd1);
    chk("hold.b_valid",   32'(b_valid), 32'd1);
    tick();
    chk("hold.m1_grant", 32'(a_grant), 32'b10);
    chk("hold.tmo_off",  32'(a_tmo),   32'd0);
    tcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b_tmo) tcount++;
    end
    chk("nolimit.tmo_count", 32'(tcount), 32'd0);
    chk("nolimit.grant",     32'(b_grant), 32'b01);

    // Lone master under MAX_HOLD=4 keeps the bus, then reset mid-CONNECT.
    do_reset();
    req = 2'b01;
    tick();
    id_in = 2'b00; tick();
    id_in = 2'b01; tick();
    tcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_tmo) tcount++;
    end
    chk("alone.tmo_count", 32'(tcount), 32'd0);
    chk("alone.valid",     32'(a_valid), 32'd1);
    chk("alone.slave",     32'(a_slave), 32'd1);
    rst = 1'b1;
    tick();
    chk_idle_a("rst_connect");
    rst = 1'b0; req = 2'b00;
    tick();

    // Leave last=0 via abort, then reset during ID: master 0 must still win next.
    req = 2'b01;
    tick();
    id_in = 2'b00; tick();
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    chk("rst_id.pre_grant", 32'(a_grant), 32'b01);
    rst = 1'b1;
    tick();
    chk_idle_a("rst_id");
    rst = 1'b0;
    req = 2'b11;
    tick();
    chk("rst_id.last_reset", 32'(a_grant), 32'b01);
    chk("rst_id.b_last",     32'(b_grant), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
